svm_mem_sequencer: RTL and testbench

Parametrised memory/compute sequencer for the SVM datapath. It runs one classification per `en` pulse in four phases:
- Load: writes the test vector into pixel memory, with data-valid handshake.
- Settle: fixed stall.
- Compute: sweeps every support vector over every pixel, driving MAC clear/last strobes.
- Decision: pulses `decision_funct_en` for the decision-function stage.
It sits between the pixel/SV memories and the kernel MAC + decision-function blocks. It replaces the free-running single-shot controller with a restartable, pausable one.

---
 rtl/svm_pkg.sv | 19 +
 rtl/svm_wrap_counter.sv | 32 +++
 rtl/svm_mem_sequencer.sv | 150 +++++++++++++++
 tb/tb_svm_mem_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared definitions for the SVM datapath blocks.
//   state_t            : sequencer FSM encoding (3-bit)
//   NUM_OF_PIXELS_DEF  : default pixels per test vector
//   NUM_OF_SV_DEF      : default support vectors per classifier
// The MAC and decision-function blocks use the same defaults.
package svm_pkg;

  localparam int unsigned NUM_OF_PIXELS_DEF = 784;
  localparam int unsigned NUM_OF_SV_DEF     = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/svm_wrap_counter.sv
// Up-counter that wraps to zero after reaching TERMINAL.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clr     : synchronous clear (wins over en)
//   en      : advance by one (wraps to 0 at TERMINAL)
//   cnt     : current count
//   at_term : cnt == TERMINAL
module svm_wrap_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TERMINAL = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

  assign at_term = (cnt == TERM_V);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_term ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/svm_mem_sequencer.sv
// Restartable, pausable memory/compute sequencer for the SVM datapath.
// One classification per en pulse: LOAD -> SETTLE -> COMPUTE -> DONE.
//   clk, rst          : clock / synchronous active-high reset
//   en                : start request, honoured only in IDLE
//   load_valid        : pixel valid during LOAD
//   pause             : backpressure, freezes COMPUTE
//   re, we, addr      : memory read/write enables and pixel address
//   sv_idx            : support vector index during COMPUTE
//   stall_MEM         : high in LOAD and SETTLE
//   mac_clear/last    : first/last pixel of current SV is being read
//   decision_funct_en : one-cycle pulse in DONE
//   busy, done        : not-IDLE flag, one-cycle completion pulse
module svm_mem_sequencer
  import svm_pkg::*;
#(
  parameter int unsigned NUM_OF_PIXELS = NUM_OF_PIXELS_DEF,
  parameter int unsigned NUM_OF_SV     = NUM_OF_SV_DEF,
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned SV_IDX_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load_valid,
  input  logic                    pause,
  output logic                    re,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [SV_IDX_WIDTH-1:0] sv_idx,
  output logic                    stall_MEM,
  output logic                    mac_clear,
  output logic                    mac_last,
  output logic                    decision_funct_en,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]   pix_cnt;
  logic [SV_IDX_WIDTH-1:0] sv_cnt;
  logic [SETTLE_W-1:0]     settle_cnt;
  logic                    pix_term, sv_term, settle_term;
  logic                    pix_en, pix_clr, sv_en, sv_clr, settle_en, settle_clr;
  logic                    run;

  // A compute step happens only on unpaused COMPUTE cycles.
  assign run = (state == ST_COMPUTE) && !pause;

  // pix_cnt wraps to 0 on the last load beat, and is cleared again in
  // SETTLE so COMPUTE always starts from pixel 0.
  assign pix_en     = ((state == ST_LOAD) && load_valid) || run;
  assign pix_clr    = (state == ST_IDLE) || (state == ST_SETTLE) || (state == ST_DONE);
  assign sv_en      = run && pix_term;
  assign sv_clr     = (state != ST_COMPUTE);
  assign settle_en  = (state == ST_SETTLE);
  assign settle_clr = (state != ST_SETTLE);

  svm_wrap_counter #(
    .WIDTH    (ADDR_WIDTH),
    .TERMINAL (NUM_OF_PIXELS - 1)
  ) u_pix_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (pix_clr),
    .en      (pix_en),
    .cnt     (pix_cnt),
    .at_term (pix_term)
  );

  svm_wrap_counter #(
    .WIDTH    (SV_IDX_WIDTH),
    .TERMINAL (NUM_OF_SV - 1)
  ) u_sv_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (sv_clr),
    .en      (sv_en),
    .cnt     (sv_cnt),
    .at_term (sv_term)
  );

  svm_wrap_counter #(
    .WIDTH    (SETTLE_W),
    .TERMINAL (SETTLE_CYCLES - 1)
  ) u_settle_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (settle_clr),
    .en      (settle_en),
    .cnt     (settle_cnt),
    .at_term (settle_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    re                = 1'b0;
    we                = 1'b0;
    addr              = '0;
    sv_idx            = '0;
    stall_MEM         = 1'b0;
    mac_clear         = 1'b0;
    mac_last          = 1'b0;
    decision_funct_en = 1'b0;
    busy              = (state != ST_IDLE);
    done              = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        stall_MEM = 1'b1;
        we        = load_valid;
        addr      = pix_cnt;
        if (load_valid && pix_term) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        stall_MEM = 1'b1;
        if (settle_term) state_nxt = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        re        = !pause;
        addr      = pix_cnt;
        sv_idx    = sv_cnt;
        mac_clear = !pause && (pix_cnt == '0);
        mac_last  = !pause && pix_term;
        if (run && pix_term && sv_term) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        decision_funct_en = 1'b1;
        done              = 1'b1;
        state_nxt         = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_svm_mem_sequencer.sv
module tb_svm_mem_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Small instance (4 pixels, 2 SVs, 2 settle cycles)
  logic       a_rst = 1'b1, a_en = 1'b0, a_lv = 1'b0, a_pause = 1'b0;
  logic       a_re, a_we, a_stall, a_clear, a_last, a_dfe, a_busy, a_done;
  logic [1:0] a_addr;
  logic [0:0] a_sv;

  // Default instance (784 / 10 / 10)
  logic       b_rst = 1'b1, b_en = 1'b0, b_lv = 1'b0, b_pause = 1'b0;
  logic       b_re, b_we, b_stall, b_clear, b_last, b_dfe, b_busy, b_done;
  logic [9:0] b_addr;
  logic [3:0] b_sv;

  svm_mem_sequencer #(
    .NUM_OF_PIXELS (4),
    .NUM_OF_SV     (2),
    .SETTLE_CYCLES (2),
    .ADDR_WIDTH    (2),
    .SV_IDX_WIDTH  (1)
  ) dut_a (
    .clk (clk), .rst (a_rst), .en (a_en), .load_valid (a_lv), .pause (a_pause),
    .re (a_re), .we (a_we), .addr (a_addr), .sv_idx (a_sv), .stall_MEM (a_stall),
    .mac_clear (a_clear), .mac_last (a_last), .decision_funct_en (a_dfe),
    .busy (a_busy), .done (a_done)
  );

  svm_mem_sequencer dut_b (
    .clk (clk), .rst (b_rst), .en (b_en), .load_valid (b_lv), .pause (b_pause),
    .re (b_re), .we (b_we), .addr (b_addr), .sv_idx (b_sv), .stall_MEM (b_stall),
    .mac_clear (b_clear), .mac_last (b_last), .decision_funct_en (b_dfe),
    .busy (b_busy), .done (b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_pack(input int sv, input int ad, input bit c, input bit l);
    return 32'((sv << 8) | (ad << 2) | (int'(c) << 1) | int'(l));
  endfunction

  // Scoreboard queues for instance A
  int          exp_wr[$];
  logic [31:0] exp_rd[$];
  int          exp_done[$];
  int          a_stall_cnt = 0;

  always @(negedge clk) begin
    if (a_stall) a_stall_cnt++;
    if (a_we) begin
      chk("we_busy", 32'(a_busy), 32'd1);
      if (exp_wr.size() == 0) chk("wr_extra", 32'(a_addr), 32'hFFFF_FFFF);
      else                    chk("wr_addr", 32'(a_addr), 32'(exp_wr.pop_front()));
    end
    if (a_re) begin
      chk("re_busy", 32'(a_busy), 32'd1);
      if (exp_rd.size() == 0) chk("rd_extra", rd_pack(int'(a_sv), int'(a_addr), a_clear, a_last), 32'hFFFF_FFFF);
      else                    chk("rd", rd_pack(int'(a_sv), int'(a_addr), a_clear, a_last), exp_rd.pop_front());
    end
    if ((a_clear || a_last) && !a_re) chk("mac_without_re", 32'({a_clear, a_last}), 32'd0);
    if (a_done || a_dfe) begin
      chk("dfe_eq_done", 32'(a_dfe), 32'(a_done));
      if (exp_done.size() == 0) chk("done_extra", 32'(cyc), 32'hFFFF_FFFF);
      else                      chk("done_cyc", 32'(cyc), 32'(exp_done.pop_front()));
    end
  end

  // Instance B tracking
  int         b_rd_cnt = 0, b_wr_cnt = 0;
  logic [9:0] b_last_addr = '0;
  logic [3:0] b_last_sv = '0;
  logic       b_last_ml = 1'b0;

  always @(negedge clk) begin
    if (b_we) b_wr_cnt++;
    if (b_re) begin
      b_rd_cnt++;
      b_last_addr = b_addr;
      b_last_sv   = b_sv;
      b_last_ml   = b_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected events for one full run whose en is driven in cycle c0.
  task automatic push_run(input int c0, input int extra);
    for (int a = 0; a < 4; a++) exp_wr.push_back(a);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        exp_rd.push_back(rd_pack(s, a, a == 0, a == 3));
    exp_done.push_back(c0 + 15 + extra);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((a_busy || exp_rd.size() != 0 || exp_done.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk(tag, 32'd1, 32'd0);
  endtask

  function automatic logic [31:0] a_outs();
    return 32'({a_re, a_we, a_stall, a_clear, a_last, a_dfe, a_busy, a_done, a_sv, a_addr});
  endfunction

  function automatic logic [31:0] b_outs();
    return 32'({b_re, b_we, b_stall, b_clear, b_last, b_dfe, b_busy, b_done, b_sv, b_addr});
  endfunction

  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

  initial begin
    int c0, s0;
    bit seen;

    repeat (3) step();
    @(negedge clk);
    chk("reset_outs_a", a_outs(), 32'd0);
    chk("reset_outs_b", b_outs(), 32'd0);
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Nominal run
    step();
    c0 = cyc; s0 = a_stall_cnt;
    push_run(c0, 0);
    a_en = 1'b1; a_lv = 1'b1;
    step();
    a_en = 1'b0;
    wait_idle("timeout_nominal", 100);
    chk("stall_nominal", 32'(a_stall_cnt - s0), 32'd6);

    // Load gaps
    step();
    c0 = cyc; s0 = a_stall_cnt;
    push_run(c0, 3);
    a_lv = 1'b0; a_en = 1'b1;
    step();
    a_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_lv = pat[i][0];
      step();
    end
    a_lv = 1'b0;
    wait_idle("timeout_gaps", 100);
    chk("stall_gaps", 32'(a_stall_cnt - s0), 32'd9);

    // Pause for 3 cycles while addr=2, sv_idx=1
    step();
    c0 = cyc;
    push_run(c0, 3);
    a_lv = 1'b1; a_en = 1'b1;
    step();
    a_en = 1'b0;
    repeat (12) step();
    a_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pause_hold", 32'({a_re, a_clear, a_last, a_sv, a_addr}), 32'({1'b0, 1'b0, 1'b0, 1'b1, 2'd2}));
      step();
    end
    a_pause = 1'b0;
    wait_idle("timeout_pause", 100);

    // Reset during COMPUTE at sv_idx=1
    step();
    c0 = cyc;
    for (int a = 0; a < 4; a++) exp_wr.push_back(a);
    for (int a = 0; a < 4; a++) exp_rd.push_back(rd_pack(0, a, a == 0, a == 3));
    exp_rd.push_back(rd_pack(1, 0, 1'b1, 1'b0));
    a_en = 1'b1;
    step();
    a_en = 1'b0;
    repeat (10) step();
    a_rst = 1'b1;
    step();
    a_rst = 1'b0;
    @(negedge clk);
    chk("midop_reset_outs", a_outs(), 32'd0);
    step();
    c0 = cyc;
    push_run(c0, 0);
    a_en = 1'b1;
    step();
    a_en = 1'b0;
    wait_idle("timeout_after_reset", 100);

    // en held high through a run and its DONE cycle
    step();
    c0 = cyc;
    push_run(c0, 0);
    push_run(c0 + 16, 0);
    a_en = 1'b1;
    repeat (17) step();
    a_en = 1'b0;
    wait_idle("timeout_en_held", 100);
    repeat (5) step();

    // Default parameters, continuous load
    c0 = cyc;
    b_en = 1'b1; b_lv = 1'b1;
    step();
    b_en = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 9000 && !seen; n++) begin
      @(negedge clk);
      if (b_done) begin
        seen = 1'b1;
        chk("b_done_cyc", 32'(cyc), 32'(c0 + 8635));
        chk("b_dfe", 32'(b_dfe), 32'd1);
        chk("b_last_read", 32'({b_last_ml, b_last_sv, b_last_addr}), 32'({1'b1, 4'd9, 10'd783}));
        chk("b_rd_cnt", 32'(b_rd_cnt), 32'd7840);
        chk("b_wr_cnt", 32'(b_wr_cnt), 32'd784);
      end
    end
    if (!seen) chk("b_timeout", 32'd1, 32'd0);
    step();
    step();
    chk("b_idle", 32'(b_busy), 32'd0);

    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    chk("done_left", 32'(exp_done.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
